shift_sequencer: RTL and testbench

//  Multi-bit shift controller for the Forth core's single-bit shifter.
//  - Accepts one request: operand, shift type and amount (0..15).
//  - Iterates the 1-bit shifter N times, feeding each result back as the next operand.
//  - Returns the final value on a valid/ready response channel.
//  - Sits between the ALU/decoder (requester) and the shifter (slave port below).

---
 rtl/shift_sequencer_pkg.sv | 27 ++
 rtl/shift_sequencer_if.sv | 30 +++
 rtl/shift_sequencer.sv | 85 ++++++++
 tb/tb_shift_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-bit shift sequencer: shift-op encodings
// understood by the single-bit shifter, FSM states and datapath defaults.
package shift_sequencer_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned AMT_W_DEF = 4;

    // Shifter control encodings; NOSHIFT makes the shifter pass its operand through.
    typedef enum logic [1:0] {
        NOSHIFT         = 2'b00,
        LOGICALRIGHT    = 2'b01,
        SHIFTLEFT       = 2'b10,
        ARITHMETICRIGHT = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Ops whose result stays zero once it has become zero (sign fill aside).
    function automatic logic op_zero_sticky(input shift_op_e op);
        return (op == LOGICALRIGHT) || (op == SHIFTLEFT);
    endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response and shifter-side signals of the shift sequencer.
// slave: the sequencer's view; master: the requester plus attached shifter.
interface shift_sequencer_if
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AMT_W = AMT_W_DEF
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [AMT_W-1:0] req_amt;
    logic [WIDTH-1:0] req_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] sh_t;
    logic [1:0]       sh_ctrl;
    logic [WIDTH-1:0] sh_result;

    modport slave (
        input  req_valid, req_op, req_amt, req_data, rsp_ready, sh_result,
        output req_ready, rsp_valid, rsp_data, sh_t, sh_ctrl
    );

    modport master (
        output req_valid, req_op, req_amt, req_data, rsp_ready, sh_result,
        input  req_ready, rsp_valid, rsp_data, sh_t, sh_ctrl
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit shift controller: iterates an external single-bit shifter N times,
// feeding each result back as the next operand, then returns the final value
// on a valid/ready response channel.
// Optional: SHIFT_SEQ_ZERO_SKIP_EN ends the iteration early once a logical or
// left shift has produced zero (the remaining steps cannot change it).
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned AMT_W = AMT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    shift_op_e        op_q,    op_d;
    logic [AMT_W-1:0] cnt_q,   cnt_d;

    // State register with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            op_q    <= NOSHIFT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: latch request in IDLE, one shifter step per SHIFT cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    acc_d = bus.req_data;
                    op_d  = shift_op_e'(bus.req_op);
                    cnt_d = bus.req_amt;
                    if ((bus.req_amt == '0) || (shift_op_e'(bus.req_op) == NOSHIFT)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = bus.sh_result;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = ST_DONE;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
                end else if ((bus.sh_result == '0) && op_zero_sticky(op_q)) begin
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: shifter sees the accumulator; its control is only active while shifting.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE) && !rst;
        bus.rsp_valid = (state_q == ST_DONE);
        bus.rsp_data  = (state_q == ST_DONE) ? acc_q : '0;
        bus.sh_t      = acc_q;
        bus.sh_ctrl   = (state_q == ST_SHIFT) ? op_q : NOSHIFT;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer with a behavioural single-bit shifter
// on the sh_* side. Expected results come from whole-amount shift arithmetic.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_sequencer_if #(.WIDTH(W), .AMT_W(AW)) bus ();
    shift_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Single-bit shifter, combinational.
    always_comb begin
        case (bus.sh_ctrl)
            2'b01:   bus.sh_result = {1'b0, bus.sh_t[W-1:1]};
            2'b10:   bus.sh_result = {bus.sh_t[W-2:0], 1'b0};
            2'b11:   bus.sh_result = {bus.sh_t[W-1], bus.sh_t[W-1:1]};
            default: bus.sh_result = bus.sh_t;
        endcase
    end

    typedef struct {
        logic [W-1:0] data;
        int unsigned  lat;
        int unsigned  acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        busy = 1'b0;
    logic        force_stall = 1'b0;
    logic        rand_bp = 1'b0;
    logic        was_valid = 1'b0;
    logic        expect_idle = 1'b0;
    logic [W-1:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input int unsigned amt,
                                                input logic [W-1:0] d);
        logic [W-1:0] r;
        case (op)
            2'b01:   r = d >> amt;
            2'b10:   r = d << amt;
            2'b11:   r = W'($signed(d) >>> amt);
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int unsigned ref_steps(input logic [1:0] op, input int unsigned amt,
                                              input logic [W-1:0] d);
        if (op == 2'b00) return 0;
`ifdef SHIFT_SEQ_ZERO_SKIP_EN
        if (op == 2'b01 || op == 2'b10) begin
            for (int unsigned i = 1; i <= amt; i++) begin
                if (ref_result(op, i, d) == '0) return i;
            end
        end
`endif
        return amt;
    endfunction

    // Response readiness: constant high, random backpressure, or forced stall.
    initial begin
        bus.rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = force_stall ? 1'b0 : (rand_bp ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Monitor: compares each response with the scoreboard head and watches handshake rules.
    always @(negedge clk) begin
        if (rst) begin
            was_valid   = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
                chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                expect_idle = 1'b0;
            end
            if (busy) chk("busy_req_ready", 32'(bus.req_ready), 32'd0);
            if (bus.rsp_valid) begin
                chk("rsp_sh_ctrl", 32'(bus.sh_ctrl), 32'd0);
                if (!was_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got data %0h expected no response", bus.rsp_data);
                    end else begin
                        chk("rsp_data", 32'(bus.rsp_data), 32'(sb[0].data));
                        chk("rsp_latency", cyc - sb[0].acc_cyc, sb[0].lat);
                    end
                    held      = bus.rsp_data;
                    was_valid = 1'b1;
                end else begin
                    chk("rsp_stable", 32'(bus.rsp_data), 32'(held));
                end
                if (bus.rsp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    was_valid   = 1'b0;
                    busy        = 1'b0;
                    expect_idle = 1'b1;
                end
            end
        end
    end

    // Issue one request; garbage req_* is presented while busy and must be ignored.
    task automatic do_req(input logic [1:0] op, input int unsigned amt, input logic [W-1:0] d,
                          input int unsigned stall);
        int unsigned n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_amt   = AW'(amt);
        bus.req_data  = d;
        e.data    = ref_result(op, amt, d);
        e.lat     = ref_steps(op, amt, d) + 1;
        e.acc_cyc = cyc;
        sb.push_back(e);
        if (stall > 0) force_stall = 1'b1;
        @(posedge clk);
        #1;
        busy          = 1'b1;
        bus.req_valid = (stall > 0) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.req_op    = 2'($urandom);
        bus.req_amt   = AW'($urandom);
        bus.req_data  = W'($urandom);
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) begin
            chk("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
            sb.delete();
            busy = 1'b0;
        end
        if (stall > 0) begin
            repeat (stall - 1) @(negedge clk);
            force_stall = 1'b0;
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int unsigned n;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_amt   = '0;
        bus.req_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(bus.rsp_data),  32'd0);
        chk("rst_sh_t",      32'(bus.sh_t),      32'd0);
        chk("rst_sh_ctrl",   32'(bus.sh_ctrl),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_idle_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed cases
        do_req(2'b10, 4,  16'h0003, 0);
        do_req(2'b01, 0,  16'hBEEF, 0);
        do_req(2'b00, 9,  16'h1234, 0);
        do_req(2'b01, 15, 16'h8000, 0);
        do_req(2'b11, 15, 16'h8000, 0);
        do_req(2'b11, 3,  16'h4F00, 0);
        do_req(2'b10, 5,  16'h00A5, 5);
        do_req(2'b10, 12, 16'h4000, 0);
        do_req(2'b01, 6,  16'h0000, 0);

        // Reset during the third SHIFT cycle
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_amt   = AW'(8);
        bus.req_data  = 16'h0101;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        sb.delete();
        busy = 1'b0;
        @(negedge clk);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("postrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("postrst_sh_ctrl",   32'(bus.sh_ctrl),   32'd0);
        chk("postrst_sh_t",      32'(bus.sh_t),      32'd0);
        do_req(2'b10, 8, 16'h0101, 0);

        // Randomized traffic with backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            do_req(2'($urandom), $urandom_range(0, 15),
                   ($urandom_range(0, 7) == 0) ? W'(1 << $urandom_range(0, 15)) : W'($urandom),
                   0);
        end

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
